microwave_timer_ctrl: RTL and testbench
=======================================

# microwave_timer_ctrl

Parametrised microwave cook-timer controller. It loads a cook time, counts it down in prescaled ticks while the magnetron enable `p` is asserted, and supports pause, door interlock, cancel and add-time. It replaces the fixed 4-bit two-clock timer with a single-clock, width-configurable FSM. It sits between the front-panel input decoder and the power-stage driver.

## Interface
- `TW`, 8: width of cook-time value and countdown register.
- `PRESCALE`, 4: `clk` cycles per time unit; must be ≥1.
- `ADD_STEP`, 10: units added by `start` while cooking.
- `BEEP_LEN`, 3: cycles `beep` is held on entry to DONE.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tin`  in  TW  cook time to load.
- `load`  in  1  load `tin` (level-sampled each cycle).
- `start`  in  1  start/resume; add-time while cooking.
- `pause`  in  1  pause request.
- `cancel`  in  1  abort to IDLE.
- `door`  in  1  door open (1 = open).
- `p`  out  1  power enable.
- `busy`  out  1  high in COOK or PAUSE.
- `done`  out  1  high in DONE.
- `tleft`  out  TW  remaining time units.
- `beep`  out  1  end-of-cook beep.

## Operation
- States: IDLE, READY, COOK, PAUSE, DONE. All state, `tleft` and prescaler are registers. Outputs `p`, `busy`, `done` are Moore decodes of the state register: `p` = COOK, `busy` = COOK|PAUSE, `done` = DONE.
- Input priority in every state: `cancel` > `door` > `load` > `pause` > `start`.
- IDLE:
  - `load` with `tin`≠0 → READY, `tleft`=`tin`.
  - `load` with `tin`=0 is ignored.
- READY:
  - `cancel` → IDLE, `tleft`=0.
  - `load` reloads `tleft`; `tin`=0 → IDLE.
  - `start` with `door`=0 → COOK, prescaler=0.
  - `start` with `door`=1 is ignored.
- COOK:
  - Prescaler counts 0..PRESCALE-1. At the terminal count it wraps to 0 and `tleft` decrements by 1.
  - Decrement from 1 → `tleft`=0 and state → DONE in the same edge.
  - `door` or `pause` → PAUSE. Prescaler and `tleft` are frozen, not cleared.
  - `cancel` → IDLE, `tleft`=0.
  - `start` → `tleft` += ADD_STEP, saturating at 2^TW−1. If a decrement coincides, apply the decrement first, then the add.
  - `load` is ignored.
- PAUSE:
  - `start` with `door`=0 → COOK, resuming the frozen prescaler phase.
  - `cancel` → IDLE, `tleft`=0.
  - `load` is ignored.
- DONE:
  - `load` with `tin`≠0 → READY.
  - `start` or `cancel` → IDLE.
  - Otherwise DONE is held.
- Prescaler width is clog2(PRESCALE), minimum 1 bit. With PRESCALE=1, `tleft` decrements every COOK cycle.

## Timing
- Reset values: state=IDLE, `tleft`=0, prescaler=0. All outputs are 0: `p`, `busy`, `done`, `beep`=0, `tleft`=0.
- Reset is asynchronous: `rst` forces all outputs low without waiting for a clock edge, including mid-cook.
- Command latency is 1 cycle: a command sampled at edge N takes effect in state/outputs after edge N.
- Cook duration: `p` stays high for exactly `tin`×PRESCALE cycles when cooking is uninterrupted; `done` rises on the cycle `p` falls.
- Door interlock: `p` falls one edge after `door` rises.
- Pause/resume: paused cycles are excluded from the cook count. Total powered cycles remain `tin`×PRESCALE plus any added time.

## Configuration
- `MW_BEEP_EN` defined:
  - `beep` goes high on the edge entering DONE and stays high for BEEP_LEN cycles, using an internal counter.
  - Leaving DONE or asserting `rst` clears `beep` immediately.
- `MW_BEEP_EN` undefined: `beep` is tied to 0 and no counter is built. The port exists in both builds.

## Test plan
Test plan uses TW=8, PRESCALE=4, ADD_STEP=10, BEEP_LEN=3, `MW_BEEP_EN` defined unless noted.
- Basic cook: `tin`=3, `load`, then `start` → `p`=1 for 12 cycles. `tleft` goes 3→2→1→0 at cycles 4, 8, 12. `done`=1 and `p`=0 together.
- Door mid-cook: open door at cycle 6 for 5 cycles, then `start` → PAUSE with `tleft`=2 held. Resume completes after 6 more powered cycles, 12 total.
- Add-time saturation: `tin`=250, cook, pulse `start` → `tleft`=255, not 4. Second test: `tin`=20 → `tleft`=30.
- Priority: `cancel` and `start` in the same READY cycle → IDLE, `tleft`=0, `p` never high. `load` with `tin`=0 in IDLE → state stays IDLE.
- Async reset mid-cook: raise `rst` between clock edges while cooking → `p`, `busy`, `tleft` go to 0 before the next edge. After release the block is in IDLE.
- Beep: on DONE, `beep`=1 for exactly 3 cycles. Build without `MW_BEEP_EN` → `beep` stays 0 and all other results are identical.

Source files
------------

// File: rtl/microwave_timer_ctrl.sv
// Cook-timer FSM: loads a time, counts it down in PRESCALE-cycle units while powering, handles
// pause, door interlock, cancel and add-time. Optional end-of-cook beep under `MW_BEEP_EN.
module microwave_timer_ctrl #(
    parameter int TW       = 8,
    parameter int PRESCALE = 4,
    parameter int ADD_STEP = 10,
    parameter int BEEP_LEN = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [TW-1:0] tin,
    input  logic          load,
    input  logic          start,
    input  logic          pause,
    input  logic          cancel,
    input  logic          door,
    output logic          p,
    output logic          busy,
    output logic          done,
    output logic [TW-1:0] tleft,
    output logic          beep
);
    localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [TW:0]     TMAX     = {1'b0, {TW{1'b1}}};
    localparam logic [TW:0]     ADD_W    = (TW+1)'(ADD_STEP);

    if (PRESCALE < 1 || BEEP_LEN < 1) begin : g_bad_cfg
        $error("microwave_timer_ctrl: PRESCALE and BEEP_LEN must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_COOK,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tleft_q, tleft_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          p_q, busy_q, done_q;

    logic          tick;
    logic [TW-1:0] tdec;
    logic [TW:0]   sum;

    always_comb begin
        state_d = state_q;
        tleft_d = tleft_q;
        pre_d   = pre_q;
        tick    = (pre_q == PRE_LAST);
        tdec    = tick ? tleft_q - 1'b1 : tleft_q;
        sum     = {1'b0, tdec} + ADD_W;
        case (state_q)
            S_IDLE: begin
                if (!cancel && load && tin != '0) begin
                    state_d = S_READY;
                    tleft_d = tin;
                end
            end
            S_READY: begin
                if (cancel) begin
                    state_d = S_IDLE;
                    tleft_d = '0;
                end else if (load) begin
                    tleft_d = tin;
                    if (tin == '0) state_d = S_IDLE;
                end else if (start && !door) begin
                    state_d = S_COOK;
                    pre_d   = '0;
                end
            end
            S_COOK: begin
                if (cancel) begin
                    state_d = S_IDLE;
                    tleft_d = '0;
                    pre_d   = '0;
                end else begin
                    // The cycle just spent powered always counts, even on the edge that pauses.
                    pre_d   = tick ? '0 : pre_q + 1'b1;
                    tleft_d = tdec;
                    if (tick && tleft_q == TW'(1)) begin
                        state_d = S_DONE;
                    end else if (door || pause) begin
                        state_d = S_PAUSE;
                    end else if (start) begin
                        tleft_d = (sum > TMAX) ? {TW{1'b1}} : sum[TW-1:0];
                    end
                end
            end
            S_PAUSE: begin
                if (cancel) begin
                    state_d = S_IDLE;
                    tleft_d = '0;
                    pre_d   = '0;
                end else if (start && !door) begin
                    state_d = S_COOK;
                end
            end
            S_DONE: begin
                if (cancel) begin
                    state_d = S_IDLE;
                    tleft_d = '0;
                end else if (load && tin != '0) begin
                    state_d = S_READY;
                    tleft_d = tin;
                end else if (start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                tleft_d = '0;
                pre_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tleft_q <= '0;
            pre_q   <= '0;
            p_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tleft_q <= tleft_d;
            pre_q   <= pre_d;
            p_q     <= (state_d == S_COOK);
            busy_q  <= (state_d == S_COOK) || (state_d == S_PAUSE);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign p     = p_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign tleft = tleft_q;

`ifdef MW_BEEP_EN
    localparam int BW = (BEEP_LEN > 1) ? $clog2(BEEP_LEN) : 1;

    logic [BW-1:0] bcnt_q;
    logic          beep_q;

    // Counter holds the number of beep cycles still owed after the current one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beep_q <= 1'b0;
            bcnt_q <= '0;
        end else if (state_d == S_DONE && state_q != S_DONE) begin
            beep_q <= 1'b1;
            bcnt_q <= BW'(BEEP_LEN - 1);
        end else if (state_d == S_DONE && bcnt_q != '0) begin
            bcnt_q <= bcnt_q - 1'b1;
        end else begin
            beep_q <= 1'b0;
            bcnt_q <= '0;
        end
    end

    assign beep = beep_q;
`else
    assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed bench for microwave_timer_ctrl: a cycle-level model that tracks powered cycles owed,
// checked against the DUT every cycle, plus literal expectations for the key scenarios.
module tb_microwave_timer_ctrl;
    localparam int TW  = 8;
    localparam int P   = 4;
    localparam int ADD = 10;
    localparam int BL  = 3;
    localparam int TMAX = 255;
`ifdef MW_BEEP_EN
    localparam int EXP_BEEPS = BL;
`else
    localparam int EXP_BEEPS = 0;
`endif

    logic          clk = 1'b0, rst = 1'b0;
    logic [TW-1:0] tin = '0;
    logic          load = 1'b0, start = 1'b0, pause = 1'b0, cancel = 1'b0, door = 1'b0;
    logic          p, busy, done, beep;
    logic [TW-1:0] tleft;

    int n_cmp = 0, n_bad = 0;
    int pcount = 0, bcount = 0;
    int trace[$];

    microwave_timer_ctrl #(.TW(TW), .PRESCALE(P), .ADD_STEP(ADD), .BEEP_LEN(BL)) dut (
        .clk(clk), .rst(rst), .tin(tin), .load(load), .start(start), .pause(pause),
        .cancel(cancel), .door(door), .p(p), .busy(busy), .done(done), .tleft(tleft), .beep(beep)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: the timer owes m_rem powered cycles; displayed time is that rounded up to units.
    localparam int M_IDLE = 0, M_READY = 1, M_COOK = 2, M_PAUSE = 3, M_DONE = 4;
    int m_mode = M_IDLE, m_rem = 0, m_set = 0, m_age = 0;
    int m_t, m_ph, m_t2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE; m_rem = 0; m_set = 0; m_age = 0;
        end else begin
            m_age++;
            case (m_mode)
                M_IDLE:
                    if (!cancel && load && tin != 0) begin m_set = tin; m_mode = M_READY; end
                M_READY:
                    if (cancel) m_mode = M_IDLE;
                    else if (load) begin
                        if (tin == 0) m_mode = M_IDLE; else m_set = tin;
                    end else if (start && !door) begin
                        m_rem = m_set * P; m_mode = M_COOK;
                    end
                M_COOK:
                    if (cancel) m_mode = M_IDLE;
                    else begin
                        m_rem--;
                        if (m_rem == 0) begin m_mode = M_DONE; m_age = 0; end
                        else if (door || pause) m_mode = M_PAUSE;
                        else if (start) begin
                            m_t  = (m_rem + P - 1) / P;
                            m_ph = m_t * P - m_rem;
                            m_t2 = (m_t + ADD > TMAX) ? TMAX : m_t + ADD;
                            m_rem = m_t2 * P - m_ph;
                        end
                    end
                M_PAUSE:
                    if (cancel) m_mode = M_IDLE;
                    else if (start && !door) m_mode = M_COOK;
                M_DONE:
                    if (cancel) m_mode = M_IDLE;
                    else if (load && tin != 0) begin m_set = tin; m_mode = M_READY; end
                    else if (start) m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
        end
    end

    function automatic int exp_tleft();
        if (m_mode == M_READY) return m_set;
        if (m_mode == M_COOK || m_mode == M_PAUSE) return (m_rem + P - 1) / P;
        return 0;
    endfunction

    always @(negedge clk) begin
        check("model_p", int'(p), int'(m_mode == M_COOK));
        check("model_busy", int'(busy), int'(m_mode == M_COOK || m_mode == M_PAUSE));
        check("model_done", int'(done), int'(m_mode == M_DONE));
        check("model_tleft", int'(tleft), exp_tleft());
`ifdef MW_BEEP_EN
        check("model_beep", int'(beep), int'(m_mode == M_DONE && m_age < BL));
`else
        check("model_beep", int'(beep), 0);
`endif
        if (p) begin pcount++; trace.push_back(int'(tleft)); end
        if (beep) bcount++;
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic do_load(input int v);
        tin = TW'(v); load = 1'b1; cyc(1); load = 1'b0;
    endtask
    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask
    task automatic pulse_cancel();
        cancel = 1'b1; cyc(1); cancel = 1'b0;
    endtask
    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (!done && k < budget) begin cyc(1); k++; end
        check(name, int'(done), 1);
    endtask

    initial begin
        // Async reset seen before any clock edge
        #1 rst = 1'b1;
        #2;
        check("rst_p", int'(p), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_tleft", int'(tleft), 0);
        check("rst_beep", int'(beep), 0);
        @(posedge clk); #1 rst = 1'b0;
        cyc(2);

        // Basic cook of 3 units
        do_load(3);
        check("ready_tleft", int'(tleft), 3);
        check("ready_busy", int'(busy), 0);
        pcount = 0; bcount = 0; trace.delete();
        pulse_start();
        wait_done("basic_done", 40);
        check("basic_p_cycles", pcount, 12);
        check("basic_p_low_at_done", int'(p), 0);
        check("basic_trace_size", trace.size(), 12);
        if (trace.size() == 12) begin
            check("basic_tleft_c3", trace[3], 3);
            check("basic_tleft_c4", trace[4], 2);
            check("basic_tleft_c8", trace[8], 1);
        end
        cyc(5);
        check("beep_cycles", bcount, EXP_BEEPS);
        check("done_held", int'(done), 1);
        pulse_start();
        check("done_to_idle", int'(done), 0);

        // Door opened mid-cook for 5 cycles
        do_load(3);
        pcount = 0;
        pulse_start();
        cyc(5);
        door = 1'b1;
        cyc(1);
        check("door_p", int'(p), 0);
        check("door_busy", int'(busy), 1);
        check("door_tleft", int'(tleft), 2);
        check("door_pcount", pcount, 6);
        cyc(4);
        door = 1'b0;
        check("door_still_paused", int'(p), 0);
        pulse_start();
        wait_done("door_done", 40);
        check("door_total_p", pcount, 12);
        pulse_start();

        // Pause input mid-cook
        do_load(2);
        pcount = 0;
        pulse_start();
        cyc(2);
        pause = 1'b1; cyc(1); pause = 1'b0;
        cyc(3);
        check("pause_tleft", int'(tleft), 2);
        check("pause_busy", int'(busy), 1);
        pulse_start();
        wait_done("pause_done", 40);
        check("pause_total_p", pcount, 8);
        pulse_cancel();

        // Add-time with and without saturation
        do_load(250);
        pulse_start();
        pulse_start();
        check("add_sat_tleft", int'(tleft), 255);
        pulse_cancel();
        check("cancel_tleft", int'(tleft), 0);
        check("cancel_busy", int'(busy), 0);
        do_load(20);
        pulse_start();
        pulse_start();
        check("add_tleft", int'(tleft), 30);
        pulse_cancel();

        // cancel beats start in READY; load of 0 ignored in IDLE
        do_load(5);
        pcount = 0;
        cancel = 1'b1; start = 1'b1; cyc(1); cancel = 1'b0; start = 1'b0;
        check("prio_tleft", int'(tleft), 0);
        check("prio_busy", int'(busy), 0);
        cyc(3);
        check("prio_no_power", pcount, 0);
        do_load(0);
        check("load0_tleft", int'(tleft), 0);
        pulse_start();
        cyc(2);
        check("load0_no_power", pcount, 0);

        // Async reset between edges while cooking
        do_load(9);
        pulse_start();
        cyc(3);
        check("pre_rst_p", int'(p), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_p", int'(p), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_tleft", int'(tleft), 0);
        @(posedge clk); #1 rst = 1'b0;
        pcount = 0;
        pulse_start();
        cyc(2);
        check("post_rst_idle", pcount, 0);
        check("post_rst_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
